// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: samples the camera bus in the clk domain and packs byte pairs into RGB565 frame-buffer writes.
// Define CAPTURE_ERR_EN to add the frame_err line/pixel-count checker output.
module ov7670_capture #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [15:0]       pix_data,
    output logic              frame_done,
`ifdef CAPTURE_ERR_EN
    output logic              frame_err,
`endif
    output logic              busy
);

    localparam int COL_W = $clog2(H_RES + 1);
    localparam int ROW_W = $clog2(V_RES + 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_RES);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_RES);

    localparam logic [0:0] ST_WAIT_FRAME = 1'b0;
    localparam logic [0:0] ST_CAPTURE    = 1'b1;

    // Bit layout of the synchronised bundle: {pclk, vsync, href, data[7:0]}
    logic [10:0] sync1_q;
    logic [10:0] sync2_q;
    logic [2:0]  sync3_q;

    logic pclk_rise;
    logic byte_valid;
    logic href_fall;
    logic vsync_fall;
    logic vsync_rise;

    logic       byte_ev_q;
    logic       href_fall_q;
    logic       vsync_fall_q;
    logic       vsync_rise_q;
    logic [7:0] byte_q;

    logic [0:0]        state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pix_we_q, pix_we_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic              frame_done_q, frame_done_d;

`ifdef CAPTURE_ERR_EN
    localparam int LPIX_W = $clog2(H_RES + 2);
    localparam int LCNT_W = $clog2(V_RES + 2);
    localparam logic [LPIX_W-1:0] LPIX_MAX = LPIX_W'(H_RES + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(V_RES + 1);

    logic [LPIX_W-1:0] line_pix_q, line_pix_d;
    logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;
`endif

    assign pclk_rise  = sync2_q[10] & ~sync3_q[2];
    assign vsync_rise = sync2_q[9] & ~sync3_q[1];
    assign vsync_fall = ~sync2_q[9] & sync3_q[1];
    assign href_fall  = ~sync2_q[8] & sync3_q[0];
    // A byte that arrives together with the href fall still belongs to the line
    assign byte_valid = pclk_rise & (sync2_q[8] | sync3_q[0]);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        pix_we_d     = 1'b0;
        pix_addr_d   = pix_addr_q;
        pix_data_d   = pix_data_q;
        frame_done_d = 1'b0;
`ifdef CAPTURE_ERR_EN
        line_pix_d   = line_pix_q;
        line_cnt_d   = line_cnt_q;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;
`endif
        case (state_q)
            ST_WAIT_FRAME: begin
                if (vsync_fall_q && en) begin
                    state_d = ST_CAPTURE;
                    phase_d = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
`ifdef CAPTURE_ERR_EN
                    line_pix_d = '0;
                    line_cnt_d = '0;
                    line_err_d = 1'b0;
`endif
                end
            end
            default: begin
                if (byte_ev_q) begin
                    if (!phase_q) begin
                        hi_d    = byte_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < COL_MAX && row_q < ROW_MAX) begin
                            pix_we_d   = 1'b1;
                            pix_data_d = {hi_q, byte_q};
                            pix_addr_d = addr_q;
                            addr_d     = addr_q + ADDR_W'(1);
                        end
                        if (col_q < COL_MAX) begin
                            col_d = col_q + COL_W'(1);
                        end
`ifdef CAPTURE_ERR_EN
                        if (line_pix_q < LPIX_MAX) begin
                            line_pix_d = line_pix_q + LPIX_W'(1);
                        end
`endif
                    end
                end
                // Line end sees the column count after any same-cycle pixel
                if (href_fall_q) begin
                    phase_d = 1'b0;
                    if (col_d != '0 && row_q < ROW_MAX) begin
                        row_d = row_q + ROW_W'(1);
                    end
                    col_d = '0;
`ifdef CAPTURE_ERR_EN
                    if (line_pix_d != '0) begin
                        if (line_pix_d != LPIX_W'(H_RES)) begin
                            line_err_d = 1'b1;
                        end
                        if (line_cnt_q < LCNT_MAX) begin
                            line_cnt_d = line_cnt_q + LCNT_W'(1);
                        end
                    end
                    line_pix_d = '0;
`endif
                end
                if (vsync_rise_q) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_WAIT_FRAME;
`ifdef CAPTURE_ERR_EN
                    frame_err_d  = line_err_d || (line_cnt_d != LCNT_W'(V_RES));
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            byte_ev_q    <= 1'b0;
            href_fall_q  <= 1'b0;
            vsync_fall_q <= 1'b0;
            vsync_rise_q <= 1'b0;
            byte_q       <= '0;
            state_q      <= ST_WAIT_FRAME;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            pix_we_q     <= 1'b0;
            pix_addr_q   <= '0;
            pix_data_q   <= '0;
            frame_done_q <= 1'b0;
`ifdef CAPTURE_ERR_EN
            line_pix_q   <= '0;
            line_cnt_q   <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`endif
        end else begin
            sync1_q      <= {cam_pclk, cam_vsync, cam_href, cam_data};
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q[10:8];
            byte_ev_q    <= byte_valid;
            href_fall_q  <= href_fall;
            vsync_fall_q <= vsync_fall;
            vsync_rise_q <= vsync_rise;
            byte_q       <= sync2_q[7:0];
            state_q      <= state_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            pix_we_q     <= pix_we_d;
            pix_addr_q   <= pix_addr_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
`ifdef CAPTURE_ERR_EN
            line_pix_q   <= line_pix_d;
            line_cnt_q   <= line_cnt_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    assign pix_we     = pix_we_q;
    assign pix_addr   = pix_addr_q;
    assign pix_data   = pix_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_CAPTURE);
`ifdef CAPTURE_ERR_EN
    assign frame_err  = frame_err_q;
`endif

endmodule
